heap_feeder: RTL



---
 rtl/heap_feeder.sv | 79 +++++++
 1 files changed

// File: rtl/heap_feeder.sv
// heap_feeder: packs keyed records into heap words and sequences the heap's
// init/en/flush controls per frame, holding off new frames until the heap drains.
module heap_feeder #(
  parameter int DATA_WIDTH   = 32,
  parameter int KEY_WIDTH    = 16,
  parameter int NLEVELS      = 4,
  parameter int INIT_CYCLES  = 2,
  parameter int DRAIN_CYCLES = 2*(2**(NLEVELS+1)-1)+4
) (
  input  logic                              clk,
  input  logic                              rstn,
  input  logic [KEY_WIDTH-1:0]              s_key,
  input  logic [DATA_WIDTH-KEY_WIDTH-3:0]   s_payload,
  input  logic                              s_valid,
  input  logic                              s_last,
  output logic                              s_ready,
  output logic [DATA_WIDTH-1:0]             heap_din,
  output logic                              heap_en,
  output logic                              heap_init,
  output logic                              heap_flush,
  output logic                              busy,
  output logic                              frame_done,
  output logic [15:0]                       frame_count,
  output logic                              overflow
);
  localparam int HEAP_SIZE = 2**(NLEVELS+1)-1;
  localparam int CW0 = $clog2(DRAIN_CYCLES > INIT_CYCLES ? DRAIN_CYCLES : INIT_CYCLES);
  localparam int CW = CW0 > 7 ? CW0 : 7;
  typedef enum logic [2:0] {IDLE, INIT, STREAM, FLUSH, DRAIN} state_t;
  state_t state, state_nxt;
  logic [CW-1:0] cnt;
  logic acc, start;
  assign s_ready = state == STREAM;
  assign busy = state != IDLE;
  assign acc = s_valid & s_ready;
  assign start = state == IDLE && s_valid;
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    state_nxt = s_valid ? INIT : IDLE;
      INIT:    state_nxt = cnt == '0 ? STREAM : INIT;
      STREAM:  state_nxt = acc && s_last ? FLUSH : STREAM;
      FLUSH:   state_nxt = DRAIN;
      DRAIN:   state_nxt = cnt == '0 ? IDLE : DRAIN;
      default: state_nxt = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) state <= IDLE;
    else state <= state_nxt;
  // One counter serves both INIT and DRAIN; it idles at zero elsewhere.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt         <= '0;
      heap_din    <= '0;
      heap_en     <= 1'b0;
      heap_init   <= 1'b0;
      heap_flush  <= 1'b0;
      frame_done  <= 1'b0;
      frame_count <= '0;
      overflow    <= 1'b0;
    end else begin
      cnt        <= start ? CW'(INIT_CYCLES-1) : state == FLUSH ? CW'(DRAIN_CYCLES-1) :
                    cnt != '0 ? cnt - CW'(1) : cnt;
      heap_init  <= start;
      heap_flush <= state == FLUSH;
      frame_done <= state == DRAIN && cnt == '0;
      heap_en    <= acc;
      if (acc) heap_din <= {2'b00, s_payload, s_key};
      if (start) begin
        frame_count <= '0;
        overflow    <= 1'b0;
      end else if (acc) begin
        frame_count <= frame_count != 16'hFFFF ? frame_count + 16'd1 : frame_count;
        overflow    <= overflow | (frame_count >= 16'(HEAP_SIZE));
      end
    end
  end
endmodule
